// File: rtl/iir_biquad_cascade.sv
// Cascade of NSEC direct-form-I biquad sections sharing one MAC unit.
// Each sample takes 6 cycles per section: five MAC steps, then a write-back
// that rounds, saturates and shifts the section's delay line.
module iir_biquad_cascade #(
    parameter int DW   = 10,
    parameter int CW   = 16,
    parameter int FRAC = 14,
    parameter int NSEC = 2,
    parameter int ACCW = 40
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DW-1:0]         data_in,
    output logic                         out_valid,
    output logic signed [DW-1:0]         data_out,
    output logic                         ovf,
    output logic                         busy,
    input  logic                         clear,
    input  logic                         coef_we,
    input  logic [$clog2(5*NSEC)-1:0]    coef_addr,
    input  logic signed [CW-1:0]         coef_data
);

    localparam int NCOEF = 5 * NSEC;
    localparam int AW    = $clog2(NCOEF);
    localparam int SW    = (NSEC > 1) ? $clog2(NSEC) : 1;
    localparam int PW    = DW + CW;

    localparam logic signed [CW-1:0]   B0_ONE = CW'(1) << FRAC;
    localparam logic signed [ACCW-1:0] HALF   = ACCW'(1) << (FRAC - 1);
    localparam logic signed [ACCW-1:0] MAXV   = (ACCW'(1) << (DW - 1)) - ACCW'(1);
    localparam logic signed [ACCW-1:0] MINV   = -MAXV - ACCW'(1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB} state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      sec_q, sec_d;
    logic [2:0]         k_q, k_d;

    logic signed [CW-1:0]   coef_q [NCOEF];
    logic signed [DW-1:0]   x1_q [NSEC];
    logic signed [DW-1:0]   x2_q [NSEC];
    logic signed [DW-1:0]   y1_q [NSEC];
    logic signed [DW-1:0]   y2_q [NSEC];
    logic signed [DW-1:0]   xin_q;
    logic signed [ACCW-1:0] acc_q;
    logic                   ovf_acc_q;
    logic                   out_valid_q;
    logic                   ovf_q;
    logic signed [DW-1:0]   data_out_q;

    logic                   accept;
    logic                   last_sec;
    logic [AW-1:0]          cidx;
    logic signed [CW-1:0]   coef_sel;
    logic signed [DW-1:0]   opnd;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] acc_next;
    logic signed [ACCW-1:0] rnd;
    logic signed [DW-1:0]   sat;
    logic                   clip;

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = ~in_ready;
    assign accept    = in_ready && in_valid;
    assign last_sec  = (sec_q == SW'(NSEC - 1));
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign ovf       = ovf_q;

    // MAC operand selection, product accumulation, rounding and saturation
    always_comb begin
        cidx     = AW'(5 * int'(sec_q) + int'(k_q));
        coef_sel = coef_q[cidx];
        opnd     = '0;
        case (k_q)
            3'd0:    opnd = xin_q;
            3'd1:    opnd = x1_q[sec_q];
            3'd2:    opnd = x2_q[sec_q];
            3'd3:    opnd = y1_q[sec_q];
            default: opnd = y2_q[sec_q];
        endcase
        prod     = coef_sel * opnd;
        acc_next = (k_q >= 3'd3) ? acc_q - ACCW'(prod) : acc_q + ACCW'(prod);
        rnd      = (acc_q + HALF) >>> FRAC;
        clip     = 1'b0;
        if (rnd > MAXV) begin
            sat  = MAXV[DW-1:0];
            clip = 1'b1;
        end else if (rnd < MINV) begin
            sat  = MINV[DW-1:0];
            clip = 1'b1;
        end else begin
            sat  = rnd[DW-1:0];
        end
    end

    // Sequencer next-state: IDLE -> MAC(s,0..4) -> WB(s) -> next section or IDLE
    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_MAC;
                    sec_d   = '0;
                    k_d     = '0;
                end
            end
            S_MAC: begin
                if (k_q == 3'd4) begin
                    state_d = S_WB;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            S_WB: begin
                k_d = '0;
                if (last_sec) begin
                    state_d = S_IDLE;
                    sec_d   = '0;
                end else begin
                    state_d = S_MAC;
                    sec_d   = sec_q + SW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            sec_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            k_q     <= k_d;
        end
    end

    // Datapath: coefficient bank, delay lines, accumulator and output registers
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            for (int unsigned i = 0; i < NCOEF; i++) begin
                coef_q[i] <= (i % 5 == 0) ? B0_ONE : '0;
            end
            for (int unsigned i = 0; i < NSEC; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
            xin_q       <= '0;
            acc_q       <= '0;
            ovf_acc_q   <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            data_out_q  <= '0;
        end else begin
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (clear) begin
                        for (int unsigned i = 0; i < NSEC; i++) begin
                            x1_q[i] <= '0;
                            x2_q[i] <= '0;
                            y1_q[i] <= '0;
                            y2_q[i] <= '0;
                        end
                    end
                    if (accept) begin
                        xin_q     <= data_in;
                        acc_q     <= '0;
                        ovf_acc_q <= 1'b0;
                    end else if (coef_we && (int'(coef_addr) < NCOEF)) begin
                        coef_q[coef_addr] <= coef_data;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_next;
                end
                S_WB: begin
                    x2_q[sec_q] <= x1_q[sec_q];
                    x1_q[sec_q] <= xin_q;
                    y2_q[sec_q] <= y1_q[sec_q];
                    y1_q[sec_q] <= sat;
                    // section output becomes the next section's input
                    xin_q       <= sat;
                    acc_q       <= '0;
                    ovf_acc_q   <= ovf_acc_q | clip;
                    if (last_sec) begin
                        data_out_q  <= sat;
                        out_valid_q <= 1'b1;
                        ovf_q       <= ovf_acc_q | clip;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Directed + randomized bench for iir_biquad_cascade against a floating-free
// integer model of the cascaded biquad equations.
module tb_iir_biquad_cascade;

    localparam int DW   = 10;
    localparam int CW   = 16;
    localparam int FRAC = 14;
    localparam int NSEC = 2;
    localparam int ACCW = 40;
    localparam int NC   = 5 * NSEC;
    localparam int AW   = $clog2(NC);
    localparam int LAT  = 6 * NSEC;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic signed [DW-1:0]  data_in;
    logic                  out_valid;
    logic signed [DW-1:0]  data_out;
    logic                  ovf;
    logic                  busy;
    logic                  clear;
    logic                  coef_we;
    logic [AW-1:0]         coef_addr;
    logic signed [CW-1:0]  coef_data;

    int ncomp = 0;
    int nfail = 0;

    // reference model state
    int mc [NC];
    int mx1 [NSEC];
    int mx2 [NSEC];
    int my1 [NSEC];
    int my2 [NSEC];

    always #5 clk = ~clk;

    iir_biquad_cascade #(
        .DW(DW), .CW(CW), .FRAC(FRAC), .NSEC(NSEC), .ACCW(ACCW)
    ) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .out_valid(out_valid), .data_out(data_out), .ovf(ovf),
        .busy(busy), .clear(clear), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data)
    );

    task automatic check(input string tag, input int got, input int exp);
        ncomp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) mc[i] = (i % 5 == 0) ? (1 << FRAC) : 0;
        model_clear();
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < NSEC; s++) begin
            mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
        end
    endfunction

    // y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2, rounded half up and clipped
    function automatic int model_step(input int x, output bit ov);
        longint acc, r;
        int v = x;
        ov = 1'b0;
        for (int s = 0; s < NSEC; s++) begin
            acc = longint'(mc[5*s]) * v + longint'(mc[5*s+1]) * mx1[s]
                + longint'(mc[5*s+2]) * mx2[s] - longint'(mc[5*s+3]) * my1[s]
                - longint'(mc[5*s+4]) * my2[s];
            r = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
            if (r > 511) begin r = 511; ov = 1'b1; end
            if (r < -512) begin r = -512; ov = 1'b1; end
            mx2[s] = mx1[s]; mx1[s] = v;
            my2[s] = my1[s]; my1[s] = int'(r);
            v = int'(r);
        end
        return v;
    endfunction

    task automatic wr_coef(input int addr, input int val);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = AW'(addr); coef_data = CW'(val);
        @(negedge clk);
        coef_we = 1'b0;
        mc[addr] = val;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
    endtask

    // send one sample (optionally with clear), check latency, value and ovf
    task automatic send(input string tag, input int x, input bit with_clr, output int got);
        int cyc;
        int exp;
        bit eov;
        @(negedge clk);
        check({tag, ".ready"}, int'(in_ready), 1);
        in_valid = 1'b1; data_in = DW'(x); clear = with_clr;
        @(negedge clk);
        in_valid = 1'b0; clear = 1'b0;
        if (with_clr) model_clear();
        exp = model_step(x, eov);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, ".lat"}, cyc, LAT);
        got = int'(data_out);
        check({tag, ".data"}, got, exp);
        check({tag, ".ovf"}, int'(ovf), int'(eov));
        check({tag, ".rdy_out"}, int'(in_ready), 1);
    endtask

    initial begin
        int got;
        int cyc;
        int idx;
        int nout;
        int acc_t [$];
        int exp_q [$];
        int ins [3];
        bit eov;

        rst_n = 1'b0; in_valid = 1'b0; data_in = '0; clear = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset state
        check("rst.in_ready", int'(in_ready), 1);
        check("rst.busy", int'(busy), 0);
        check("rst.out_valid", int'(out_valid), 0);
        check("rst.data_out", int'(data_out), 0);
        check("rst.ovf", int'(ovf), 0);

        // T1 unity passthrough
        send("t1", 100, 1'b0, got);
        check("t1.const", got, 100);

        // T2 b0 = 0.5, round half up
        wr_coef(0, 8192);
        send("t2a", 100, 1'b0, got);
        check("t2a.const", got, 50);
        send("t2b", -3, 1'b0, got);
        check("t2b.const", got, -1);

        // T3 saturation both rails
        wr_coef(0, 32767);
        send("t3a", 511, 1'b0, got);
        check("t3a.const", got, 511);
        send("t3b", -512, 1'b0, got);
        check("t3b.const", got, -512);
        send("t3c", 0, 1'b0, got);

        // T4 one-pole recursion y = x + 0.5*y1, then clear
        wr_coef(0, 16384);
        wr_coef(3, -8192);
        do_clear();
        send("t4.0", 256, 1'b0, got);
        check("t4.0c", got, 256);
        send("t4.1", 0, 1'b0, got);
        check("t4.1c", got, 128);
        send("t4.2", 0, 1'b0, got);
        check("t4.2c", got, 64);
        send("t4.3", 0, 1'b0, got);
        do_clear();
        send("t4.clr", 0, 1'b0, got);
        check("t4.clrc", got, 0);
        send("t4.4", 200, 1'b0, got);
        send("t4.5", 0, 1'b0, got);
        // clear coinciding with accept: cleared first (else 50 would leak in)
        send("t4.clracc", 0, 1'b1, got);
        check("t4.clraccc", got, 0);

        // coef write coinciding with accept is dropped
        @(negedge clk);
        in_valid = 1'b1; data_in = DW'(40); coef_we = 1'b1; coef_addr = '0; coef_data = '0;
        @(negedge clk);
        in_valid = 1'b0; coef_we = 1'b0;
        got = model_step(40, eov);
        cyc = 0;
        while (!out_valid && cyc < 40) begin @(negedge clk); cyc++; end
        check("wracc.lat", cyc, LAT);
        check("wracc.data", int'(data_out), got);

        // randomized coefficients and samples against the model
        do_clear();
        for (int n = 0; n < 2; n++) begin
            wr_coef(5 * n + 0, int'($urandom_range(16384)) - 8192);
            wr_coef(5 * n + 1, int'($urandom_range(16384)) - 8192);
            wr_coef(5 * n + 2, int'($urandom_range(8192)) - 4096);
            wr_coef(5 * n + 3, int'($urandom_range(8192)) - 4096);
            wr_coef(5 * n + 4, int'($urandom_range(4096)) - 2048);
        end
        for (int n = 0; n < 8; n++) begin
            send("rnd", int'($urandom_range(1023)) - 512, 1'b0, got);
        end

        // T5 continuous in_valid: 13-cycle spacing, busy write ignored
        ins[0] = int'($urandom_range(400)) - 200;
        ins[1] = int'($urandom_range(400)) - 200;
        ins[2] = int'($urandom_range(400)) - 200;
        idx = 0; nout = 0; cyc = 0;
        while (nout < 3 && cyc < 80) begin
            @(negedge clk);
            coef_we = 1'b0;
            if (out_valid) begin
                check("t5.data", int'(data_out), exp_q.pop_front());
                nout++;
            end
            if (idx < 3) begin
                in_valid = 1'b1;
                data_in = DW'(ins[idx]);
                if (in_ready) begin
                    acc_t.push_back(cyc);
                    exp_q.push_back(model_step(ins[idx], eov));
                    idx++;
                end else if (cyc % 13 == 4) begin
                    coef_we = 1'b1; coef_addr = '0; coef_data = '0;
                end
            end else begin
                in_valid = 1'b0;
            end
            cyc++;
        end
        in_valid = 1'b0; coef_we = 1'b0;
        check("t5.nout", nout, 3);
        if (acc_t.size() == 3) begin
            check("t5.gap1", acc_t[1] - acc_t[0], 13);
            check("t5.gap2", acc_t[2] - acc_t[1], 13);
        end else begin
            check("t5.naccept", acc_t.size(), 3);
        end

        // T6 reset during MAC(1,2) aborts and restores passthrough
        @(negedge clk);
        in_valid = 1'b1; data_in = DW'(123);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6.ready", int'(in_ready), 1);
        check("t6.no_valid", int'(out_valid), 0);
        nout = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) nout++;
        end
        check("t6.no_pulse", nout, 0);
        model_reset();
        send("t6.pass", 77, 1'b0, got);
        check("t6.passc", got, 77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
